// File: rtl/weight_proxy_minabs_scanner.sv
// weight_proxy_minabs_scanner
//  Streams NUM_WEIGHTS signed weights of one PE row, skips entries flagged in the
//  excluded mask, and reports the weight with the smallest absolute value and its
//  index as the proxy candidate for BISR remapping.
// Ports:
//  clk, rst_n  rising-edge clock, asynchronous active-low reset
//  start       begin a scan (accepted only while idle); excl_mask latched then
//  w_valid     weight stream valid; w_data carries weights in index order
//  w_ready     scanner accepts a weight (scanning only)
//  busy        scan in progress or completing
//  done        one-cycle pulse, results valid from this cycle on
//  min_found   at least one non-excluded weight was seen
//  min_idx     index of the smallest-magnitude non-excluded weight
//  min_val     original signed value of that weight
module weight_proxy_minabs_scanner #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_WEIGHTS = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_WEIGHTS-1:0]         excl_mask,
  input  logic                           w_valid,
  input  logic [DATA_W-1:0]              w_data,
  output logic                           w_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           min_found,
  output logic [$clog2(NUM_WEIGHTS)-1:0] min_idx,
  output logic [DATA_W-1:0]              min_val
);

  localparam int unsigned IDX_W = $clog2(NUM_WEIGHTS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [IDX_W-1:0]       count;
  logic [NUM_WEIGHTS-1:0] mask;

  logic start_acc_c;
  logic hs_c;
  logic last_c;
  logic take_c;

  // Two's complement magnitude; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? DATA_W'(-x) : x;
  endfunction

  // Handshake and candidate-selection terms.
  always_comb begin
    start_acc_c = (state == ST_IDLE) && start;
    hs_c        = w_valid && w_ready;
    last_c      = hs_c && (count == LAST_IDX);
    // Strict less-than keeps the earliest index on magnitude ties.
    take_c      = hs_c && !mask[count] &&
                  (!min_found || (mag(w_data) < mag(min_val)));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_acc_c) state_nxt = ST_SCAN;
      ST_SCAN: if (last_c)      state_nxt = ST_DONE;
      ST_DONE:                  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // State register; status outputs are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      w_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      w_ready <= (state_nxt == ST_SCAN);
      busy    <= (state_nxt != ST_IDLE);
      done    <= (state_nxt == ST_DONE);
    end
  end

  // Scan datapath: slot counter, latched mask and running minimum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      mask      <= '0;
      min_found <= 1'b0;
      min_idx   <= '0;
      min_val   <= '0;
    end else if (start_acc_c) begin
      count     <= '0;
      mask      <= excl_mask;
      min_found <= 1'b0;
      min_idx   <= '0;
      min_val   <= '0;
    end else if (hs_c) begin
      // Excluded entries still consume an index slot.
      count <= last_c ? '0 : IDX_W'(count + 1'b1);
      if (take_c) begin
        min_found <= 1'b1;
        min_idx   <= count;
        min_val   <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_weight_proxy_minabs_scanner.sv
// Bench for weight_proxy_minabs_scanner with a 4-entry row: directed cases for ties,
// extremes, full exclusion, stalls with ignored restarts and mid-scan reset, then
// randomized scans checked against an array-based minimum-magnitude model.
module tb_weight_proxy_minabs_scanner;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  typedef logic [DW-1:0] wvec_t [N];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  excl_mask;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          busy;
  logic          done;
  logic          min_found;
  logic [IW-1:0] min_idx;
  logic [DW-1:0] min_val;

  int vectors     = 0;
  int miscompares = 0;
  int hs_cnt      = 0;

  weight_proxy_minabs_scanner #(
    .DATA_W      (DW),
    .NUM_WEIGHTS (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .excl_mask (excl_mask),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .busy      (busy),
    .done      (done),
    .min_found (min_found),
    .min_idx   (min_idx),
    .min_val   (min_val)
  );

  always #5 clk = ~clk;

  // Independent handshake counter.
  always @(posedge clk) if (rst_n && w_valid && w_ready) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: walk the row, keep the first strictly smaller magnitude.
  function automatic void model(input wvec_t w, input logic [N-1:0] m,
                                output logic f, output logic [31:0] idx,
                                output logic [31:0] val);
    longint best = 0;
    f = 1'b0; idx = 0; val = 0;
    for (int k = 0; k < N; k++) begin
      if (!m[k]) begin
        longint s  = longint'($signed(w[k]));
        longint mg = (s < 0) ? -s : s;
        if (!f || mg < best) begin
          best = mg; f = 1'b1; idx = k; val = w[k];
        end
      end
    end
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(w_ready),   32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_found"}, 32'(min_found), 32'd0);
    chk({tag, "_idx"},   32'(min_idx),   32'd0);
    chk({tag, "_val"},   min_val,        32'd0);
  endtask

  // Full scan; gap idle cycles before each weight, optionally poking start in them.
  task automatic run_scan(input string tag, input logic [N-1:0] m, input wvec_t w,
                          input int gap, input bit poke_start);
    logic        ef;
    logic [31:0] ei;
    logic [31:0] ev;
    model(w, m, ef, ei, ev);
    @(negedge clk);
    start = 1'b1; excl_mask = m;
    @(negedge clk);
    start = 1'b0; excl_mask = ~m;
    hs_cnt = 0;
    chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gap; g++) begin
        w_valid = 1'b0;
        start   = poke_start;
        @(negedge clk);
        start   = 1'b0;
      end
      chk({tag, "_ready"}, 32'(w_ready), 32'd1);
      w_valid = 1'b1;
      w_data  = w[k];
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_data  = '0;
    chk({tag, "_done"},     32'(done),    32'd1);
    chk({tag, "_ready_lo"}, 32'(w_ready), 32'd0);
    chk({tag, "_hs"},       32'(hs_cnt),  32'(N));
    chk({tag, "_found"},    32'(min_found), 32'(ef));
    chk({tag, "_idx"},      32'(min_idx),   ei);
    chk({tag, "_val"},      min_val,        ev);
    @(negedge clk);
    chk({tag, "_done_lo"},  32'(done), 32'd0);
    chk({tag, "_idle"},     32'(busy), 32'd0);
    chk({tag, "_hold_val"}, min_val,   ev);
  endtask

  initial begin
    wvec_t       w;
    logic [N-1:0] m;
    rst_n = 1'b0; start = 1'b0; excl_mask = '0; w_valid = 1'b0; w_data = '0;
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic minimum.
    w = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF7};
    run_scan("basic", 4'b0000, w, 0, 1'b0);
    chk("basic_idx_const", 32'(min_idx), 32'd1);
    chk("basic_val_const", min_val, 32'hFFFF_FFFD);

    // Ties resolve to the earliest index.
    w = '{32'hFFFF_FFFC, 32'd4, 32'd4, 32'd8};
    run_scan("tie", 4'b0000, w, 0, 1'b0);
    chk("tie_val_const", min_val, 32'hFFFF_FFFC);
    run_scan("tie_mask", 4'b0001, w, 0, 1'b0);
    chk("tie_mask_idx_const", 32'(min_idx), 32'd1);

    // Extremes: most negative is the largest magnitude.
    w = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    run_scan("ext", 4'b0000, w, 0, 1'b0);
    chk("ext_val_const", min_val, 32'hFFFF_FFFF);

    // Everything excluded.
    w = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_scan("allx", 4'b1111, w, 0, 1'b0);
    chk("allx_found_const", 32'(min_found), 32'd0);

    // Stalls with start pokes during the scan.
    w = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF7};
    run_scan("gap", 4'b0000, w, 3, 1'b1);
    chk("gap_idx_const", 32'(min_idx), 32'd1);

    // Reset after the second handshake, then a fresh scan.
    @(negedge clk);
    start = 1'b1; excl_mask = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_valid = 1'b1; w_data = 32'(k + 1);
      @(negedge clk);
    end
    w_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    w = '{32'd9, 32'hFFFF_FFFE, 32'd6, 32'd2};
    run_scan("after_rst", 4'b0000, w, 0, 1'b0);
    chk("after_rst_idx_const", 32'(min_idx), 32'd1);

    // Randomized scans.
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 5))
          0:       w[k] = 32'h8000_0000;
          1:       w[k] = 32'h7FFF_FFFF;
          2, 3:    w[k] = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 6))
                                                      : 32'(-32'sd1 * $signed(32'($urandom_range(0, 6))));
          default: w[k] = 32'($urandom);
        endcase
      end
      m = 4'($urandom_range(0, 15));
      run_scan("rand", m, w, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
